// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared BCD types and limits for the time-of-day counter
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t UNITS_MAX      = 4'd9;
  localparam bcd_t SEC_MAX_TENS   = 4'd5;
  localparam bcd_t SEC_MAX_UNITS  = 4'd9;
  localparam bcd_t MIN_MAX_TENS   = SEC_MAX_TENS;
  localparam bcd_t MIN_MAX_UNITS  = SEC_MAX_UNITS;
  localparam bcd_t HOUR_MAX_TENS  = 4'd2;
  localparam bcd_t HOUR_MAX_UNITS = 4'd3;

  function automatic logic bcd_is(input bcd_t tens, input bcd_t units,
                                  input bcd_t ref_tens, input bcd_t ref_units);
    return (tens == ref_tens) && (units == ref_units);
  endfunction

endpackage

// File: rtl/timer_time_counter_bcd_counter60.sv
// rtl/timer_time_counter_bcd_counter60.sv - enabled BCD 00..59 counter with registered wrap pulse
module bcd_counter60
  import timer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic wrap_en,
  output bcd_t tens,
  output bcd_t units,
  output logic wrap
);

  bcd_t tens_q, tens_d;
  bcd_t units_q, units_d;
  logic wrap_q, wrap_d;
  logic at_max;

  always_comb begin
    at_max  = bcd_is(tens_q, units_q, MIN_MAX_TENS, MIN_MAX_UNITS);
    tens_d  = tens_q;
    units_d = units_q;
    wrap_d  = 1'b0;
    if (en) begin
      if (at_max) begin
        tens_d  = '0;
        units_d = '0;
        // wrap_en lets the caller hide wraps that were not produced by counting
        wrap_d  = wrap_en;
      end else if (units_q == UNITS_MAX) begin
        tens_d  = tens_q + 4'd1;
        units_d = '0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= '0;
      units_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
      wrap_q  <= wrap_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/timer_time_counter.sv
// rtl/timer_time_counter.sv - 24-hour BCD HH:MM:SS counter with 1 Hz prescaler and set-key handling
module timer_time_counter
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic min,
  input  logic hour,
  input  logic set_key,
  output bcd_t s1,
  output bcd_t s2,
  output bcd_t m1,
  output bcd_t m2,
  output bcd_t h1,
  output bcd_t h2,
  output logic tick,
  output logic sec_wrap,
  output logic min_wrap,
  output logic eoh
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d;
  logic sync1_q, sync2_q, sync3_q;
  logic set_pulse;
  bcd_t h1_q, h1_d, h2_q, h2_d;
  logic sec_carry, min_en, min_carry, hour_en;

  // prescaler: tick is registered, so it rises the cycle after the count hits its last value
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    tick_d = (cnt_q == CNT_LAST);
  end

  assign set_pulse = sync2_q & ~sync3_q;
  assign sec_carry = tick_q & bcd_is(s1, s2, SEC_MAX_TENS, SEC_MAX_UNITS);

  // minute-set steals the minute enable from the seconds carry
  always_comb begin
    min_en    = min ? set_pulse : sec_carry;
    min_carry = min_en & bcd_is(m1, m2, MIN_MAX_TENS, MIN_MAX_UNITS);
    if (min) begin
      hour_en = 1'b0;
    end else if (hour) begin
      hour_en = set_pulse;
    end else begin
      hour_en = min_carry;
    end
  end

  always_comb begin
    h1_d = h1_q;
    h2_d = h2_q;
    if (hour_en) begin
      if (bcd_is(h1_q, h2_q, HOUR_MAX_TENS, HOUR_MAX_UNITS)) begin
        h1_d = '0;
        h2_d = '0;
      end else if (h2_q == UNITS_MAX) begin
        h1_d = h1_q + 4'd1;
        h2_d = '0;
      end else begin
        h2_d = h2_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      h1_q    <= '0;
      h2_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      sync1_q <= set_key;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
    end
  end

  bcd_counter60 u_sec (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (tick_q),
    .wrap_en (1'b1),
    .tens    (s1),
    .units   (s2),
    .wrap    (sec_wrap)
  );

  bcd_counter60 u_min (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (min_en),
    .wrap_en (~min),
    .tens    (m1),
    .units   (m2),
    .wrap    (min_wrap)
  );

  assign h1   = h1_q;
  assign h2   = h2_q;
  assign tick = tick_q;
  assign eoh  = bcd_is(m1, m2, MIN_MAX_TENS, MIN_MAX_UNITS) &
                bcd_is(s1, s2, SEC_MAX_TENS, SEC_MAX_UNITS);

endmodule

// File: tb/tb_timer_time_counter.sv
// tb/tb_timer_time_counter.sv - directed self-checking bench for timer_time_counter
module tb_timer_time_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic min = 1'b0;
  logic hour = 1'b0;
  logic set_key = 1'b0;
  logic [3:0] s1, s2, m1, m2, h1, h2;
  logic tick, sec_wrap, min_wrap, eoh;
  logic [23:0] t_now;

  int n_checks = 0;
  int n_fail = 0;
  int mw_count = 0;

  timer_time_counter #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .min      (min),
    .hour     (hour),
    .set_key  (set_key),
    .s1       (s1),
    .s2       (s2),
    .m1       (m1),
    .m2       (m2),
    .h1       (h1),
    .h2       (h2),
    .tick     (tick),
    .sec_wrap (sec_wrap),
    .min_wrap (min_wrap),
    .eoh      (eoh)
  );

  always #5 clk = ~clk;

  assign t_now = {h1, h2, m1, m2, s1, s2};

  always @(posedge clk) begin
    if (min_wrap) mw_count <= mw_count + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       m;
    logic       h;
    logic [7:0] presses;
    logic [7:0] exp_h;
    logic [7:0] exp_m;
    logic       chk_m;
    logic       exp_mw;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    set_key = 1'b1;
    cyc(10);
    set_key = 1'b0;
    cyc(10);
  endtask

  task automatic do_reset(input logic m_i, input logic h_i);
    @(negedge clk);
    rst_n = 1'b0;
    min = m_i;
    hour = h_i;
    set_key = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // hour presses first (minutes drift to start_m through the seconds carry), then minute presses
  task automatic preload(input int hh, input int mm, input int start_m);
    do_reset(1'b0, 1'b1);
    for (int p = 0; p < hh; p++) press();
    min = 1'b1;
    hour = 1'b0;
    for (int p = 0; p < mm - start_m; p++) press();
  endtask

  task automatic wait_sec_wrap(input string name);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      cyc(1);
      if (sec_wrap) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    int n, ticks, since, bad_gap, mw0;
    logic found;

    vecs[0] = '{m: 1'b1, h: 1'b0, presses: 8'd3,  exp_h: 8'h00, exp_m: 8'h03, chk_m: 1'b1, exp_mw: 1'b0};
    vecs[1] = '{m: 1'b1, h: 1'b0, presses: 8'd59, exp_h: 8'h00, exp_m: 8'h59, chk_m: 1'b1, exp_mw: 1'b0};
    vecs[2] = '{m: 1'b1, h: 1'b0, presses: 8'd61, exp_h: 8'h00, exp_m: 8'h01, chk_m: 1'b1, exp_mw: 1'b0};
    vecs[3] = '{m: 1'b1, h: 1'b1, presses: 8'd5,  exp_h: 8'h00, exp_m: 8'h05, chk_m: 1'b1, exp_mw: 1'b0};
    vecs[4] = '{m: 1'b0, h: 1'b1, presses: 8'd23, exp_h: 8'h23, exp_m: 8'h00, chk_m: 1'b0, exp_mw: 1'b0};
    vecs[5] = '{m: 1'b0, h: 1'b1, presses: 8'd25, exp_h: 8'h01, exp_m: 8'h00, chk_m: 1'b0, exp_mw: 1'b0};
    vecs[6] = '{m: 1'b0, h: 1'b0, presses: 8'd5,  exp_h: 8'h00, exp_m: 8'h00, chk_m: 1'b1, exp_mw: 1'b0};

    // reset state, first tick latency, tick period, first minute carry
    cyc(2);
    check("reset_time", 32'(t_now), 32'h0);
    check("reset_pulses", 32'({tick, sec_wrap, min_wrap, eoh}), 32'h0);
    rst_n = 1'b1;
    n = 0;
    while (!tick && n < 20) begin
      cyc(1);
      n++;
    end
    check("first_tick_latency", 32'(n), 32'd4);
    cyc(1);
    check("first_second", 32'(t_now), 32'h000001);
    ticks = 1;
    since = 1;
    bad_gap = 0;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      cyc(1);
      since++;
      if (tick) begin
        if (since != 4) bad_gap++;
        since = 0;
        ticks++;
      end
      if (sec_wrap) found = 1'b1;
    end
    check("sec_wrap_seen", 32'(found), 32'd1);
    check("ticks_to_wrap", 32'(ticks), 32'd60);
    check("tick_period", 32'(bad_gap), 32'd0);
    check("first_minute", 32'(t_now), 32'h000100);
    cyc(1);
    check("sec_wrap_one_cycle", 32'(sec_wrap), 32'd0);

    // table: set presses in each mode from reset
    for (int i = 0; i < 7; i++) begin
      do_reset(vecs[i].m, vecs[i].h);
      mw0 = mw_count;
      for (int p = 0; p < int'(vecs[i].presses); p++) press();
      check($sformatf("vec%0d_hours", i), 32'({h1, h2}), 32'(vecs[i].exp_h));
      if (vecs[i].chk_m) check($sformatf("vec%0d_minutes", i), 32'({m1, m2}), 32'(vecs[i].exp_m));
      check($sformatf("vec%0d_min_wrap", i), 32'(mw_count != mw0), 32'(vecs[i].exp_mw));
    end

    // end of day rollover
    preload(23, 59, 1);
    min = 1'b0;
    check("preload_2359", 32'(t_now[23:8]), 32'h2359);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (eoh) found = 1'b1;
      else cyc(1);
    end
    check("eoh_seen", 32'(found), 32'd1);
    check("eoh_time", 32'(t_now), 32'h235959);
    n = 0;
    while (!tick && n < 8) begin
      cyc(1);
      n++;
    end
    check("pre_midnight_tick", 32'(tick), 32'd1);
    cyc(1);
    check("midnight_time", 32'(t_now), 32'h000000);
    check("midnight_pulses", 32'({sec_wrap, min_wrap, eoh}), 32'b110);
    cyc(1);
    check("min_wrap_one_cycle", 32'(min_wrap), 32'd0);

    // minute-set: presses add minutes, seconds wrap does not carry
    min = 1'b1;
    for (int p = 0; p < 3; p++) press();
    check("minset_plus3", 32'(t_now[23:8]), 32'h0003);
    wait_sec_wrap("minset_wrap_seen");
    check("minset_no_carry", 32'(t_now), 32'h000300);
    check("minset_no_min_wrap", 32'(min_wrap), 32'd0);

    // hour-set: minute roll holds hours, then hours wrap 23 -> 00
    preload(22, 59, 1);
    min = 1'b0;
    hour = 1'b1;
    wait_sec_wrap("hourset_wrap_seen");
    check("hourset_roll", 32'(t_now), 32'h220000);
    check("hourset_min_wrap", 32'(min_wrap), 32'd1);
    press();
    check("hourset_23", 32'(t_now[23:8]), 32'h2300);
    press();
    check("hourset_00", 32'(t_now[23:8]), 32'h0000);

    // held key: one increment two edges after sampling, no repeat
    hour = 1'b0;
    min = 1'b1;
    set_key = 1'b1;
    cyc(2);
    check("set_lat_edge_k1", 32'({m1, m2}), 32'h00);
    cyc(1);
    check("set_lat_edge_k2", 32'({m1, m2}), 32'h01);
    cyc(1000);
    check("held_no_repeat", 32'(t_now[23:8]), 32'h0001);
    set_key = 1'b0;
    cyc(5);
    min = 1'b0;
    wait_sec_wrap("normal_wrap_seen");
    check("normal_carry", 32'(t_now), 32'h000200);
    press();
    check("normal_press_ignored", 32'(t_now[23:8]), 32'h0002);

    // asynchronous reset mid-count
    preload(12, 34, 0);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      cyc(1);
      if ({s1, s2} == 8'h56) found = 1'b1;
    end
    cyc(1);
    check("midcount_time", 32'(t_now), 32'h123456);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_time", 32'(t_now), 32'h0);
    check("async_reset_pulses", 32'({tick, sec_wrap, min_wrap}), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    n = 0;
    while (!tick && n < 20) begin
      cyc(1);
      n++;
    end
    check("post_reset_tick", 32'(n), 32'd4);

    // key held across reset release yields one pulse
    @(negedge clk);
    rst_n = 1'b0;
    min = 1'b1;
    hour = 1'b0;
    set_key = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    check("rst_key_edge2", 32'({m1, m2}), 32'h00);
    cyc(1);
    check("rst_key_edge3", 32'({m1, m2}), 32'h01);
    cyc(20);
    check("rst_key_single", 32'({m1, m2}), 32'h01);
    set_key = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
